io_serial_tx_port: RTL

//  Memory-mapped serial transmit port: bus responder in the upper (address_bus[15]=1) I/O window,

---
 rtl/io_serial_tx_port_pkg.sv | 22 ++
 rtl/io_serial_tx_port_sync_fifo.sv | 49 ++++
 rtl/io_serial_tx_port.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/io_serial_tx_port_pkg.sv
// Shared definitions for the memory-mapped serial transmit port:
// register offsets, STATUS bit positions and transmitter state encodings.
package io_serial_tx_port_pkg;

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_BAUD   = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  localparam int STAT_EMPTY = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_BUSY  = 2;
  localparam int STAT_OVF   = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/io_serial_tx_port_sync_fifo.sv
// Small synchronous FIFO with occupancy count; a push into a full FIFO is
// accepted only when a pop happens on the same edge.
module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  localparam int AW        = $clog2(DEPTH),
  localparam int CW        = AW + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  full,
  output logic                  empty,
  output logic [CW-1:0]         count
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  // Pointers rely on DEPTH being a power of two to wrap naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/io_serial_tx_port.sv
// Memory-mapped 8N1 serial transmitter: CPU pushes bytes into a TX FIFO and
// a shift FSM sends them on txd at DIV+1 clocks per bit.
module io_serial_tx_port
  import io_serial_tx_port_pkg::*;
#(
  parameter int                   FIFO_DEPTH  = 4,
  parameter int                   DIV_WIDTH   = 8,
  parameter logic [DIV_WIDTH-1:0] DEFAULT_DIV = DIV_WIDTH'(3)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] address,
  inout  logic [7:0] data,
  input  logic       CS,
  input  logic       OE,
  input  logic       WE,
  output logic       txd,
  output logic       irq_empty
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic                 wr_en;
  logic                 rd_en;
  logic                 push;
  logic                 pop;
  logic                 full;
  logic                 empty;
  logic                 busy;
  logic                 overflow;
  logic                 ovf_clear;
  logic                 ovf;
  logic [CW-1:0]        count;
  logic [7:0]           fifo_rdata;
  logic [7:0]           rd_data;
  logic [DIV_WIDTH-1:0] div;
  logic [DIV_WIDTH-1:0] baud_cnt;
  logic [2:0]           bit_cnt;
  logic [7:0]           shift;
  tx_state_t            state;

  assign wr_en     = CS & WE;
  assign rd_en     = CS & OE & ~WE;
  assign push      = wr_en & (address == REG_TXDATA);
  assign ovf_clear = wr_en & (address == REG_STATUS) & data[STAT_OVF];
  assign overflow  = push & full & ~pop;
  assign busy      = (state != ST_IDLE);
  assign irq_empty = empty & ~busy;

  // The FIFO is drained when idle, or at the last clock of a stop bit so
  // consecutive frames follow without an idle gap.
  assign pop = ~empty & ((state == ST_IDLE) |
                         ((state == ST_STOP) & (baud_cnt == '0)));

  sync_fifo #(
    .DATA_WIDTH(8),
    .DEPTH     (FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (push),
    .pop  (pop),
    .wdata(data),
    .rdata(fifo_rdata),
    .full (full),
    .empty(empty),
    .count(count)
  );

  // A new overflow wins over a clear on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div <= DEFAULT_DIV;
      ovf <= 1'b0;
    end else begin
      if (wr_en && address == REG_BAUD) div <= data[DIV_WIDTH-1:0];
      ovf <= (ovf & ~ovf_clear) | overflow;
    end
  end

  always_comb begin
    rd_data = 8'h00;
    case (address)
      REG_TXDATA: rd_data[CW-1:0] = count;
      REG_STATUS: begin
        rd_data[STAT_EMPTY] = empty;
        rd_data[STAT_FULL]  = full;
        rd_data[STAT_BUSY]  = busy;
        rd_data[STAT_OVF]   = ovf;
      end
      REG_BAUD:   rd_data[DIV_WIDTH-1:0] = div;
      REG_RSVD:   rd_data = 8'h00;
      default:    rd_data = 8'h00;
    endcase
  end

  assign data = rd_en ? rd_data : 8'hzz;

  // Every bit reloads the divisor at its start, so a mid-frame BAUD write
  // only affects bits that begin after it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      txd      <= 1'b1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          txd <= 1'b1;
          if (!empty) begin
            shift    <= fifo_rdata;
            baud_cnt <= div;
            txd      <= 1'b0;
            state    <= ST_START;
          end
        end
        ST_START: begin
          if (baud_cnt == '0) begin
            baud_cnt <= div;
            bit_cnt  <= '0;
            txd      <= shift[0];
            state    <= ST_DATA;
          end else begin
            baud_cnt <= baud_cnt - DIV_WIDTH'(1);
          end
        end
        ST_DATA: begin
          if (baud_cnt == '0) begin
            baud_cnt <= div;
            if (bit_cnt == 3'd7) begin
              txd   <= 1'b1;
              state <= ST_STOP;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              shift   <= {1'b0, shift[7:1]};
              txd     <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt - DIV_WIDTH'(1);
          end
        end
        ST_STOP: begin
          if (baud_cnt == '0) begin
            if (!empty) begin
              shift    <= fifo_rdata;
              baud_cnt <= div;
              txd      <= 1'b0;
              state    <= ST_START;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt - DIV_WIDTH'(1);
          end
        end
        default: begin
          txd   <= 1'b1;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
